// File: rtl/topk_merge_32.sv
// rtl/topk_merge_32.sv - running top-K accumulator over sorted vectors
// Merges each beat's K largest into the best list, one element per cycle.
module topk_merge_32 #(
  parameter int DATAWIDTH  = 8,
  parameter int DATALENGTH = 32,
  parameter int K          = 8
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 valid_i,
  output logic                                 ready_o,
  input  logic                                 sign_ctrl_i,
  input  logic                                 last_i,
  input  logic [DATALENGTH-1:0][DATAWIDTH-1:0] x_i,
  output logic                                 valid_o,
  input  logic                                 ready_i,
  output logic [K-1:0][DATAWIDTH-1:0]          y_o,
  output logic [15:0]                          frame_beats_o
);

  localparam int PW = (K > 1) ? $clog2(K) : 1;
  localparam logic [PW-1:0] JLAST = PW'(K - 1);

  typedef enum logic [1:0] {S_IDLE, S_MERGE, S_OUT} state_e;
  typedef logic [K-1:0][DATAWIDTH-1:0] vec_t;

  if (K < 1 || K > DATALENGTH) begin : g_bad_k
    $error("topk_merge_32: K must be in 1..DATALENGTH");
  end

  state_e          state_q, state_d;
  vec_t            best_q, best_d, cand_q, cand_d, nxt_q, nxt_d, ext;
  logic            first_q, first_d, last_q, last_d;
  logic [PW-1:0]   pa_q, pa_d, pb_q, pb_d, j_q, j_d;
  logic [15:0]     beats_q, beats_d;
  logic            take_best;
  logic [DATAWIDTH-1:0] pick;

  // Largest K elements, largest first, regardless of input order.
  for (genvar n = 0; n < K; n++) begin : g_ext
    assign ext[n] = sign_ctrl_i ? x_i[n] : x_i[DATALENGTH-1-n];
  end

  assign take_best = best_q[pa_q] >= cand_q[pb_q];
  assign pick      = take_best ? best_q[pa_q] : cand_q[pb_q];

  always_comb begin
    state_d = state_q;
    best_d  = best_q;
    cand_d  = cand_q;
    nxt_d   = nxt_q;
    first_d = first_q;
    last_d  = last_q;
    pa_d    = pa_q;
    pb_d    = pb_q;
    j_d     = j_q;
    beats_d = beats_q;
    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          last_d = last_i;
          if (first_q) begin
            best_d  = ext;
            beats_d = 16'd1;
            first_d = 1'b0;
            state_d = last_i ? S_OUT : S_IDLE;
          end else begin
            cand_d  = ext;
            pa_d    = '0;
            pb_d    = '0;
            j_d     = '0;
            beats_d = (beats_q == 16'hFFFF) ? beats_q : beats_q + 16'd1;
            state_d = S_MERGE;
          end
        end
      end
      S_MERGE: begin
        nxt_d[j_q] = pick;
        if (take_best) pa_d = pa_q + PW'(1);
        else           pb_d = pb_q + PW'(1);
        if (j_q == JLAST) begin
          best_d  = nxt_d;
          state_d = last_q ? S_OUT : S_IDLE;
        end else begin
          j_d = j_q + PW'(1);
        end
      end
      S_OUT: begin
        if (ready_i) begin
          state_d = S_IDLE;
          first_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      best_q  <= '0;
      cand_q  <= '0;
      nxt_q   <= '0;
      first_q <= 1'b1;
      last_q  <= 1'b0;
      pa_q    <= '0;
      pb_q    <= '0;
      j_q     <= '0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      best_q  <= best_d;
      cand_q  <= cand_d;
      nxt_q   <= nxt_d;
      first_q <= first_d;
      last_q  <= last_d;
      pa_q    <= pa_d;
      pb_q    <= pb_d;
      j_q     <= j_d;
      beats_q <= beats_d;
    end
  end

  assign ready_o       = (state_q == S_IDLE);
  assign valid_o       = (state_q == S_OUT);
  assign y_o           = best_q;
  assign frame_beats_o = beats_q;

endmodule

// File: doc/topk_merge_32.md
# topk_merge_32

Running top-K accumulator directly downstream of the 32-input bitonic backend. It accepts one fully sorted 32-element vector per beat and keeps the K largest values seen in the current frame. It merges each new vector's top K against the running best list with a K-cycle sequential two-pointer merge. At the end of a frame it presents the final top-K list, largest first, over a valid/ready handshake.

## Interface
- DATAWIDTH, 8, element width; elements are unsigned.
- DATALENGTH, 32, elements per input vector.
- K, 8, number of results kept; legal range 1..DATALENGTH (elaboration error otherwise).

- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- valid_i  in  1  x_i, sign_ctrl_i and last_i are valid.
- ready_o  out  1  block can accept a vector.
- sign_ctrl_i  in  1  order of x_i: 1 = descending (x_i[0] largest), 0 = ascending (x_i[DATALENGTH-1] largest).
- last_i  in  1  this vector closes the frame.
- x_i  in  DATAWIDTH x DATALENGTH  sorted input vector.
- valid_o  out  1  y_o holds a final frame result.
- ready_i  in  1  consumer accepts the result.
- y_o  out  DATAWIDTH x K  top-K result; y_o[0] largest, non-increasing with index.
- frame_beats_o  out  16  vectors accepted in the current or just-finished frame; saturates at 16'hFFFF.

## Operation
- Storage: best[K], cand[K], nxt[K], flags first and last_q, pointers pa and pb, index j, and a state register.
- States: IDLE, MERGE, OUT. ready_o = (state==IDLE). valid_o = (state==OUT).
- Candidate extraction on accept (valid_i && ready_o):
  - When sign_ctrl_i=1: cand[n] = x_i[n].
  - When sign_ctrl_i=0: cand[n] = x_i[DATALENGTH-1-n], for n in 0..K-1.
  - last_q <= last_i on the same edge.
- Accept with first=1 (first beat of a frame):
  - best <= extracted candidate directly; no merge.
  - frame_beats_o <= 1; first <= 0.
  - Next state: OUT if last_i, else IDLE.
- Accept with first=0:
  - cand <= extracted candidate; pa, pb, j <= 0; frame_beats_o increments (saturating).
  - Next state: MERGE.
- MERGE, each cycle:
  - If best[pa] >= cand[pb]: nxt[j] <= best[pa] and pa++ (ties take best).
  - Otherwise: nxt[j] <= cand[pb] and pb++.
  - pa + pb == j always, so neither pointer exceeds K-1; no bounds logic is needed.
  - When j == K-1: best <= final list (nxt[0..K-2] plus this cycle's pick); state <= OUT if last_q, else IDLE.
  - Otherwise j++.
- OUT: y_o = best, held stable. On valid_o && ready_i: state <= IDLE, first <= 1.
  - frame_beats_o keeps its value until the next frame's first accept.
- Input transfers are never accepted in MERGE or OUT (ready_o=0). valid_i is ignored there and upstream must hold its data.
- Inputs are assumed correctly sorted per sign_ctrl_i; unsorted input gives undefined but deterministic results, with no error flag.

## Timing
- Reset (rst_i high at an edge):
  - state=IDLE, first=1, last_q=0, best/cand/nxt/y_o all 0, frame_beats_o=0.
  - ready_o=1 and valid_o=0 from the first cycle after the reset edge.
- Reset mid-MERGE or mid-OUT aborts the frame: the partial result and any un-taken output are discarded, with no valid_o pulse.
- First beat: accept edge to valid_o (if last) is 1 cycle.
- Later beat: accept edge, then K MERGE cycles, then IDLE or OUT. ready_o is low for exactly K cycles, so sustained throughput is 1 vector per K+1 cycles.
- Last beat with first=0: valid_o rises K cycles after the accept edge.
- Output handshake: valid_o stays high and y_o stays stable until ready_i. ready_i high on the first OUT cycle completes the transfer in 1 cycle, and ready_o returns high the next cycle.
- The earliest next-frame accept is the cycle after the output transfer; there is no overlap between output and input.

## Test plan
- Single-beat frame, K=4:
  - Stimulus: sign_ctrl_i=1, x_i[n]=200-n, last_i=1.
  - Response: valid_o one cycle after accept; y_o={200,199,198,197}; frame_beats_o=1.
- Two-beat merge, K=4:
  - Stimulus: beat A descending with top {50,40,30,20}; beat B with sign_ctrl_i=0 and top {45,35,25,15}, last_i=1.
  - Response: ready_o low 4 cycles after B; y_o={50,45,40,35}; frame_beats_o=2.
- Ties, K=4:
  - Stimulus: two beats, both with top {9,9,7,7}.
  - Response: y_o={9,9,9,9}.
- Backpressure:
  - Stimulus: hold ready_i=0 for 10 cycles in OUT; pulse valid_i with new data during that time.
  - Response: y_o unchanged, ready_o=0, no accept; IDLE 1 cycle after ready_i=1.
- Reset mid-merge, K=8:
  - Stimulus: assert rst_i on MERGE cycle 3.
  - Response: next cycle valid_o=0, ready_o=1, frame_beats_o=0, y_o all 0; a new single-beat frame then returns only its own values.
- Long frame, K=1:
  - Stimulus: 300 beats, max value 250 placed in beat 177.
  - Response: y_o[0]=250; frame_beats_o=300.
